pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Tracks destination-register info of in-flight instructions and selects EX-stage operand forwarding.
- Inserts a one-cycle stall plus bubble for load-use hazards.
- Freezes the whole pipeline while the print sink back-pressures a PrintValue instruction in MEM.

---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 74 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage hazard info, print handshake and control outputs of the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] s_id_rs1;
    logic [REG_ADDR_W-1:0] s_id_rs2;
    logic                  s_id_uses_rs1;
    logic                  s_id_uses_rs2;
    logic [REG_ADDR_W-1:0] s_id_rd;
    logic                  s_id_RegWrite;
    logic                  s_id_IsLoad;
    logic                  s_id_PrintValue;
    logic                  print_ready;
    logic                  stall_if_id;
    logic                  bubble_ex;
    logic                  freeze_all;
    logic                  print_valid;
    logic [1:0]            r_ex_fwd_rs1_sel;
    logic [1:0]            r_ex_fwd_rs2_sel;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, s_id_rs1, s_id_rs2, s_id_uses_rs1, s_id_uses_rs2, s_id_rd,
               s_id_RegWrite, s_id_IsLoad, s_id_PrintValue, print_ready,
        input  stall_if_id, bubble_ex, freeze_all, print_valid,
               r_ex_fwd_rs1_sel, r_ex_fwd_rs2_sel, stall_count
    );

    modport slave (
        input  id_valid, s_id_rs1, s_id_rs2, s_id_uses_rs1, s_id_uses_rs2, s_id_rd,
               s_id_RegWrite, s_id_IsLoad, s_id_PrintValue, print_ready,
        output stall_if_id, bubble_ex, freeze_all, print_valid,
               r_ex_fwd_rs1_sel, r_ex_fwd_rs2_sel, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: EX/MEM destination tracking, operand forwarding select, load-use stall
// and whole-pipeline freeze while the print sink back-pressures.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 16
) (
    input logic sys_clock,
    input logic reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, PRINT_WAIT} state_t;
    state_t state;
    logic ex_valid, ex_rw, ex_ld, ex_pv;
    logic mem_valid, mem_rw, mem_pv;
    logic [REG_ADDR_W-1:0] ex_rd, mem_rd;
    logic m_ex1, m_ex2, m_mem1, m_mem2, lu, pv, frz, bub;
    logic [1:0] sel1, sel2, fwd1, fwd2;
    logic [CNT_W-1:0] cnt;

    assign m_ex1  = ex_valid & ex_rw & (ex_rd == bus.s_id_rs1) & (bus.s_id_rs1 != '0) & bus.s_id_uses_rs1;
    assign m_ex2  = ex_valid & ex_rw & (ex_rd == bus.s_id_rs2) & (bus.s_id_rs2 != '0) & bus.s_id_uses_rs2;
    assign m_mem1 = mem_valid & mem_rw & (mem_rd == bus.s_id_rs1) & (bus.s_id_rs1 != '0) & bus.s_id_uses_rs1;
    assign m_mem2 = mem_valid & mem_rw & (mem_rd == bus.s_id_rs2) & (bus.s_id_rs2 != '0) & bus.s_id_uses_rs2;
    assign lu  = bus.id_valid & (m_ex1 | m_ex2) & ex_ld;
    assign pv  = (state == PRINT_WAIT) | (mem_valid & mem_pv);
    assign frz = pv & ~bus.print_ready;
    assign bub = lu & ~frz;
    // A load in EX cannot forward yet; once it reaches MEM the MEM/WB path supplies it.
    assign sel1 = (m_ex1 & ~ex_ld) ? 2'd1 : m_mem1 ? 2'd2 : 2'd0;
    assign sel2 = (m_ex2 & ~ex_ld) ? 2'd1 : m_mem2 ? 2'd2 : 2'd0;

    assign bus.stall_if_id      = bub;
    assign bus.bubble_ex        = bub;
    assign bus.freeze_all       = frz;
    assign bus.print_valid      = pv;
    assign bus.r_ex_fwd_rs1_sel = fwd1;
    assign bus.r_ex_fwd_rs2_sel = fwd2;
    assign bus.stall_count      = cnt;

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            ex_valid  <= 1'b0;
            ex_rw     <= 1'b0;
            ex_ld     <= 1'b0;
            ex_pv     <= 1'b0;
            ex_rd     <= '0;
            mem_valid <= 1'b0;
            mem_rw    <= 1'b0;
            mem_pv    <= 1'b0;
            mem_rd    <= '0;
            fwd1      <= 2'd0;
            fwd2      <= 2'd0;
            cnt       <= '0;
        end else begin
            state <= frz ? PRINT_WAIT : RUN;
            if (!frz) begin
                ex_valid  <= bus.id_valid & ~bub;
                ex_rw     <= bus.s_id_RegWrite;
                ex_ld     <= bus.s_id_IsLoad;
                ex_pv     <= bus.s_id_PrintValue;
                ex_rd     <= bus.s_id_rd;
                mem_valid <= ex_valid;
                mem_rw    <= ex_rw;
                mem_pv    <= ex_pv;
                mem_rd    <= ex_rd;
                fwd1      <= bub ? 2'd0 : sel1;
                fwd2      <= bub ? 2'd0 : sel2;
            end
            if ((bub | frz) && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed per-cycle vectors; registered results queued at drive time and
// compared after the clock edge that produces them.
module tb_pipe_hazard_ctrl;
    logic sys_clock = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       pv;
    } id_t;

    typedef struct packed {
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];

    pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
    pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (.sys_clock(sys_clock), .reset(reset), .bus(bus));

    always #5 sys_clock = ~sys_clock;

    function automatic id_t nop();
        return '0;
    endfunction
    function automatic id_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return '{v: 1'b1, rs1: a, u1: 1'b1, rs2: b, u2: 1'b1, rd: rd, rw: 1'b1, ld: 1'b0, pv: 1'b0};
    endfunction
    function automatic id_t ldw(input logic [4:0] rd, input logic [4:0] a);
        return '{v: 1'b1, rs1: a, u1: 1'b1, rs2: 5'd0, u2: 1'b0, rd: rd, rw: 1'b1, ld: 1'b1, pv: 1'b0};
    endfunction
    function automatic id_t prt(input logic [4:0] a);
        return '{v: 1'b1, rs1: a, u1: 1'b1, rs2: 5'd0, u2: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0, pv: 1'b1};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic drive(input id_t i, input logic pr);
        bus.id_valid = i.v;
        bus.s_id_rs1 = i.rs1;
        bus.s_id_uses_rs1 = i.u1;
        bus.s_id_rs2 = i.rs2;
        bus.s_id_uses_rs2 = i.u2;
        bus.s_id_rd = i.rd;
        bus.s_id_RegWrite = i.rw;
        bus.s_id_IsLoad = i.ld;
        bus.s_id_PrintValue = i.pv;
        bus.print_ready = pr;
    endtask

    // ec = {stall, bubble, freeze, print_valid} during the cycle; e1/e2/ecnt after its edge
    task automatic cyc(input string tag, input id_t i, input logic pr, input logic [3:0] ec,
                       input logic [1:0] e1, input logic [1:0] e2, input logic [15:0] ecnt);
        exp_t e;
        drive(i, pr);
        #1;
        check({tag, ".stall"}, 32'(bus.stall_if_id), 32'(ec[3]));
        check({tag, ".bubble"}, 32'(bus.bubble_ex), 32'(ec[2]));
        check({tag, ".freeze"}, 32'(bus.freeze_all), 32'(ec[1]));
        check({tag, ".pvalid"}, 32'(bus.print_valid), 32'(ec[0]));
        q.push_back('{s1: e1, s2: e2, cnt: ecnt});
        @(posedge sys_clock);
        #1;
        e = q.pop_front();
        check({tag, ".sel1"}, 32'(bus.r_ex_fwd_rs1_sel), 32'(e.s1));
        check({tag, ".sel2"}, 32'(bus.r_ex_fwd_rs2_sel), 32'(e.s2));
        check({tag, ".cnt"}, 32'(bus.stall_count), 32'(e.cnt));
        @(negedge sys_clock);
    endtask

    initial begin
        drive(nop(), 1'b0);
        #2;
        check("rst.pvalid", 32'(bus.print_valid), 32'd0);
        check("rst.freeze", 32'(bus.freeze_all), 32'd0);
        check("rst.stall", 32'(bus.stall_if_id), 32'd0);
        check("rst.sel1", 32'(bus.r_ex_fwd_rs1_sel), 32'd0);
        check("rst.sel2", 32'(bus.r_ex_fwd_rs2_sel), 32'd0);
        check("rst.cnt", 32'(bus.stall_count), 32'd0);
        @(negedge sys_clock);
        reset = 1'b0;
        // EX forwarding of an ALU result
        cyc("t1a", alu(5'd3, 5'd1, 5'd2), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd0);
        cyc("t1b", alu(5'd4, 5'd3, 5'd0), 1'b0, 4'b0000, 2'd1, 2'd0, 16'd0);
        // load-use: one bubble, then MEM/WB forwarding
        cyc("t2a", ldw(5'd5, 5'd1), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd0);
        cyc("t2b", alu(5'd6, 5'd1, 5'd5), 1'b0, 4'b1100, 2'd0, 2'd0, 16'd1);
        cyc("t2c", alu(5'd6, 5'd1, 5'd5), 1'b0, 4'b0000, 2'd0, 2'd2, 16'd1);
        // youngest producer wins; r0 never forwards
        cyc("t3a", alu(5'd7, 5'd1, 5'd2), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd1);
        cyc("t3b", alu(5'd7, 5'd1, 5'd2), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd1);
        cyc("t3c", alu(5'd8, 5'd7, 5'd7), 1'b0, 4'b0000, 2'd1, 2'd1, 16'd1);
        cyc("t3d", alu(5'd0, 5'd1, 5'd2), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd1);
        cyc("t3e", alu(5'd0, 5'd1, 5'd2), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd1);
        cyc("t3f", alu(5'd9, 5'd0, 5'd0), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd1);
        // print back-pressured for 3 cycles
        cyc("t4a", prt(5'd1), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd1);
        cyc("t4b", alu(5'd10, 5'd9, 5'd2), 1'b0, 4'b0000, 2'd2, 2'd0, 16'd1);
        cyc("t4c", alu(5'd11, 5'd10, 5'd10), 1'b0, 4'b0011, 2'd2, 2'd0, 16'd2);
        cyc("t4d", alu(5'd11, 5'd10, 5'd10), 1'b0, 4'b0011, 2'd2, 2'd0, 16'd3);
        cyc("t4e", alu(5'd11, 5'd10, 5'd10), 1'b0, 4'b0011, 2'd2, 2'd0, 16'd4);
        cyc("t4f", alu(5'd11, 5'd10, 5'd10), 1'b1, 4'b0001, 2'd1, 2'd1, 16'd4);
        cyc("t4g", nop(), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd4);
        // load-use masked by freeze, taken on release
        cyc("t5a", prt(5'd1), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd4);
        cyc("t5b", ldw(5'd12, 5'd1), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd4);
        cyc("t5c", alu(5'd13, 5'd12, 5'd0), 1'b0, 4'b0011, 2'd0, 2'd0, 16'd5);
        cyc("t5d", alu(5'd13, 5'd12, 5'd0), 1'b0, 4'b0011, 2'd0, 2'd0, 16'd6);
        cyc("t5e", alu(5'd13, 5'd12, 5'd0), 1'b1, 4'b1101, 2'd0, 2'd0, 16'd7);
        cyc("t5f", alu(5'd13, 5'd12, 5'd0), 1'b0, 4'b0000, 2'd2, 2'd0, 16'd7);
        // reset during PRINT_WAIT
        cyc("t6a", prt(5'd1), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd7);
        cyc("t6b", alu(5'd14, 5'd13, 5'd13), 1'b0, 4'b0000, 2'd2, 2'd2, 16'd7);
        cyc("t6c", nop(), 1'b0, 4'b0011, 2'd2, 2'd2, 16'd8);
        #1;
        check("t6d.pvalid", 32'(bus.print_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t6r.pvalid", 32'(bus.print_valid), 32'd0);
        check("t6r.freeze", 32'(bus.freeze_all), 32'd0);
        check("t6r.sel1", 32'(bus.r_ex_fwd_rs1_sel), 32'd0);
        check("t6r.sel2", 32'(bus.r_ex_fwd_rs2_sel), 32'd0);
        check("t6r.cnt", 32'(bus.stall_count), 32'd0);
        @(negedge sys_clock);
        reset = 1'b0;
        cyc("t6e", nop(), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd0);
        // saturation under a long freeze
        cyc("t7a", prt(5'd1), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd0);
        cyc("t7b", nop(), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd0);
        repeat (65533) @(posedge sys_clock);
        @(negedge sys_clock);
        cyc("t7c", nop(), 1'b0, 4'b0011, 2'd0, 2'd0, 16'd65534);
        cyc("t7d", nop(), 1'b0, 4'b0011, 2'd0, 2'd0, 16'd65535);
        cyc("t7e", nop(), 1'b0, 4'b0011, 2'd0, 2'd0, 16'd65535);
        cyc("t7f", nop(), 1'b1, 4'b0001, 2'd0, 2'd0, 16'd65535);
        cyc("t7g", nop(), 1'b0, 4'b0000, 2'd0, 2'd0, 16'd65535);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
